tm1638_frame_gen: RTL and testbench

- Upstream producer for spi_fifo in the TM1638 display path.
- Snapshots a display image: 8 seven-segment digits, 8 discrete LEDs, brightness and on/off.
- Serialises the image into the fixed TM1638 command sequence as 18-bit words, one word per accepted cycle.
- Output goes straight into the spi_fifo input port (o_FIFO_Full / i_Data_Valid / i_Data).

---
 rtl/tm1638_pkg.sv | 50 +++++
 rtl/tm1638_refresh_timer.sv | 36 +++
 rtl/tm1638_frame_gen.sv | 169 ++++++++++++++++
 tb/tb_tm1638_frame_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// ---------------------------------------------------------------------------
// tm1638_pkg
// Shared definitions for the TM1638 frame generator:
//   - framing codes carried in the top two bits of every 18-bit word
//   - word field positions
//   - TM1638 command bytes and frame geometry
//   - frame generator state encoding
//   - make_word helper that packs framing + byte into a word
// ---------------------------------------------------------------------------
package tm1638_pkg;

   localparam int WORD_W      = 18;
   localparam int FRAMING_MSB = 17;
   localparam int FRAMING_LSB = 16;
   localparam int BYTE_MSB    = 7;
   localparam int BYTE_LSB    = 0;

   // Strobe framing seen by the SPI side.
   typedef enum logic [1:0] {
      FR_SINGLE = 2'b00,   // strobe opens and closes around one byte
      FR_FIRST  = 2'b01,   // strobe opens
      FR_MIDDLE = 2'b10,   // strobe stays asserted
      FR_LAST   = 2'b11    // strobe closes after this byte
   } framing_t;

   localparam logic [7:0] CMD_DATA_AUTO = 8'h40;  // write data, auto-increment
   localparam logic [7:0] CMD_ADDR0     = 8'hC0;  // set address 0
   localparam logic [7:0] CMD_DISP      = 8'h80;  // display control base

   // Mode word + address word + 16 data words + control word.
   localparam int FRAME_LEN  = 19;
   localparam int DATA_WORDS = FRAME_LEN - 3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MODE = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_CTRL = 3'd4
   } state_t;

   function automatic logic [WORD_W-1:0] make_word(input framing_t f, input logic [7:0] b);
      logic [WORD_W-1:0] w;
      w = '0;
      w[FRAMING_MSB:FRAMING_LSB] = f;
      w[BYTE_MSB:BYTE_LSB]       = b;
      return w;
   endfunction

endpackage

// File: rtl/tm1638_refresh_timer.sv
// ---------------------------------------------------------------------------
// tm1638_refresh_timer
// Free-running counter 0..REFRESH_CYCLES-1; o_Tick is high for the one cycle
// in which the counter sits at its last value, so the consumer sees the tick
// on the edge where the counter wraps.
// Ports:
//   i_Clk    system clock
//   i_Rst_n  asynchronous active-low reset (counter returns to 0)
//   o_Tick   one-cycle refresh request
// ---------------------------------------------------------------------------
module tm1638_refresh_timer #(
   parameter int unsigned REFRESH_CYCLES = 40
) (
   input  logic i_Clk,
   input  logic i_Rst_n,
   output logic o_Tick
);

   localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(REFRESH_CYCLES - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_count <= '0;
      end else if (r_count == LAST_COUNT) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_Tick = (r_count == LAST_COUNT);

endmodule

// File: rtl/tm1638_frame_gen.sv
// ---------------------------------------------------------------------------
// tm1638_frame_gen
// Snapshots a display image (8 digits, 8 LEDs, brightness, on/off) and emits
// the fixed 19-word TM1638 command sequence into spi_fifo.
// Ports:
//   i_Clk, i_Rst_n        clock, asynchronous active-low reset
//   i_Update              one-cycle frame request
//   i_Digits[63:0]        segment bytes, digit k in [8k+7:8k]
//   i_Leds[7:0]           LED k on when bit k set
//   i_Brightness[2:0]     pulse-width code
//   i_Display_On          display enable
//   i_FIFO_Full           downstream full, blocks word transfer
//   o_Data_Valid          word on o_Data is written this cycle
//   o_Data[17:0]          {framing[1:0], 8'h00, byte[7:0]}
//   o_Busy                frame in progress or pending
//
// Handshake: a word transfers at a posedge where o_Data_Valid is high.
// o_Data_Valid = (state != IDLE) & ~i_FIFO_Full, so the full flag acts as an
// inverted ready. o_Data depends only on registered state, index and
// snapshot, so it holds steady across any number of stalled cycles and every
// state transition (except leaving IDLE) is gated by an actual transfer.
// ---------------------------------------------------------------------------
module tm1638_frame_gen
   import tm1638_pkg::*;
#(
   parameter int unsigned REFRESH_CYCLES = 0
) (
   input  logic                i_Clk,
   input  logic                i_Rst_n,
   input  logic                i_Update,
   input  logic [63:0]         i_Digits,
   input  logic [7:0]          i_Leds,
   input  logic [2:0]          i_Brightness,
   input  logic                i_Display_On,
   input  logic                i_FIFO_Full,
   output logic                o_Data_Valid,
   output logic [WORD_W-1:0]   o_Data,
   output logic                o_Busy
);

   localparam logic [3:0] IDX_LAST = 4'(DATA_WORDS - 1);

   state_t              r_state;
   logic [3:0]          r_idx;
   logic                r_pending;
   logic [63:0]         r_digits;
   logic [7:0]          r_leds;
   logic [2:0]          r_bright;
   logic                r_on;

   state_t              w_state_nxt;
   logic [3:0]          w_idx_nxt;
   logic                w_pending_nxt;
   logic                w_start;
   logic                w_tick;
   logic                w_req;
   logic                w_valid;
   logic [WORD_W-1:0]   w_data;
   logic [7:0]          w_data_byte;

   generate
      if (REFRESH_CYCLES > 0) begin : g_refresh
         tm1638_refresh_timer #(
            .REFRESH_CYCLES (REFRESH_CYCLES)
         ) u_refresh_timer (
            .i_Clk   (i_Clk),
            .i_Rst_n (i_Rst_n),
            .o_Tick  (w_tick)
         );
      end else begin : g_no_refresh
         assign w_tick = 1'b0;
      end
   endgenerate

   // A refresh tick is indistinguishable from a user request.
   assign w_req   = i_Update | w_tick;
   assign w_valid = (r_state != ST_IDLE) & ~i_FIFO_Full;

   // ---------------- state register ----------------
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   // Image snapshot, captured only on the edge that leaves IDLE.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_digits <= '0;
         r_leds   <= '0;
         r_bright <= '0;
         r_on     <= 1'b0;
      end else if (w_start) begin
         r_digits <= i_Digits;
         r_leds   <= i_Leds;
         r_bright <= i_Brightness;
         r_on     <= i_Display_On;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      // Requests arriving mid-frame (including on the final word) merge
      // into a single pending frame.
      w_pending_nxt = r_pending | w_req;
      w_start       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req || r_pending) begin
               w_start       = 1'b1;
               w_state_nxt   = ST_MODE;
               w_idx_nxt     = '0;
               w_pending_nxt = 1'b0;
            end
         end
         ST_MODE: begin
            if (w_valid) w_state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            if (w_valid) begin
               w_state_nxt = ST_DATA;
               w_idx_nxt   = '0;
            end
         end
         ST_DATA: begin
            if (w_valid) begin
               if (r_idx == IDX_LAST) w_state_nxt = ST_CTRL;
               else                   w_idx_nxt   = r_idx + 4'd1;
            end
         end
         ST_CTRL: begin
            if (w_valid) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- word formation ----------------
   // Even display addresses carry a digit byte, odd ones the LED bit.
   always_comb begin
      w_data_byte = 8'h00;
      if (r_idx[0]) w_data_byte = {7'b0, r_leds[r_idx[3:1]]};
      else          w_data_byte = r_digits[{r_idx[3:1], 3'b000} +: 8];
   end

   always_comb begin
      w_data = '0;
      case (r_state)
         ST_MODE: w_data = make_word(FR_SINGLE, CMD_DATA_AUTO);
         ST_ADDR: w_data = make_word(FR_FIRST, CMD_ADDR0);
         ST_DATA: w_data = make_word((r_idx == IDX_LAST) ? FR_LAST : FR_MIDDLE, w_data_byte);
         ST_CTRL: w_data = make_word(FR_SINGLE, CMD_DISP | {4'b0000, r_on, r_bright});
         default: w_data = '0;
      endcase
   end

   assign o_Data_Valid = w_valid;
   assign o_Data       = w_data;
   assign o_Busy       = (r_state != ST_IDLE) | r_pending;

endmodule

// File: tb/tb_tm1638_frame_gen.sv
module tb_tm1638_frame_gen;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main DUT (no auto refresh)
   logic        rst_n = 1'b0;
   logic        update = 1'b0;
   logic [63:0] digits = '0;
   logic [7:0]  leds = '0;
   logic [2:0]  bright = '0;
   logic        display_on = 1'b0;
   logic        fifo_full = 1'b0;
   logic        data_valid;
   logic [17:0] data;
   logic        busy;

   // refresh DUT (REFRESH_CYCLES = 40)
   logic        rf_rst_n = 1'b0;
   logic        rf_update = 1'b0;
   logic [63:0] rf_digits = 64'h1122_3344_5566_7788;
   logic [7:0]  rf_leds = 8'h3C;
   logic [2:0]  rf_bright = 3'd4;
   logic        rf_on = 1'b1;
   logic        rf_full = 1'b0;
   logic        rf_valid;
   logic [17:0] rf_data;
   logic        rf_busy;

   tm1638_frame_gen #(.REFRESH_CYCLES(0)) dut (
      .i_Clk        (clk),
      .i_Rst_n      (rst_n),
      .i_Update     (update),
      .i_Digits     (digits),
      .i_Leds       (leds),
      .i_Brightness (bright),
      .i_Display_On (display_on),
      .i_FIFO_Full  (fifo_full),
      .o_Data_Valid (data_valid),
      .o_Data       (data),
      .o_Busy       (busy)
   );

   tm1638_frame_gen #(.REFRESH_CYCLES(40)) dut_rf (
      .i_Clk        (clk),
      .i_Rst_n      (rf_rst_n),
      .i_Update     (rf_update),
      .i_Digits     (rf_digits),
      .i_Leds       (rf_leds),
      .i_Brightness (rf_bright),
      .i_Display_On (rf_on),
      .i_FIFO_Full  (rf_full),
      .o_Data_Valid (rf_valid),
      .o_Data       (rf_data),
      .o_Busy       (rf_busy)
   );

   // ---------------- scoreboard state ----------------
   int          n_vec = 0;
   int          n_err = 0;
   int          words_done = 0;
   int          cyc = 0;
   logic [17:0] exp_q[$];
   int          word_cyc[$];
   bit          stab_en = 0;
   bit          prev_stall = 0;
   logic [17:0] prev_data = '0;
   logic        last_valid = 1'b0;

   // ---------------- reference model ----------------
   // Word n of a frame, built straight from the frame description.
   function automatic logic [17:0] model_word(input logic [63:0] d, input logic [7:0] l,
                                              input logic [2:0] b, input logic on, input int n);
      int a;
      logic [7:0] byte_v;
      logic [1:0] fr;
      if (n == 0) return {2'b00, 8'h00, 8'h40};
      if (n == 1) return {2'b01, 8'h00, 8'hC0};
      if (n == 18) return {2'b00, 8'h00, 4'b1000, on, b};
      a = n - 2;
      if (a % 2 == 0) byte_v = d[8*(a/2) +: 8];
      else            byte_v = {7'b0, l[(a-1)/2]};
      fr = (a == 15) ? 2'b11 : 2'b10;
      return {fr, 8'h00, byte_v};
   endfunction

   task automatic push_frame(input logic [63:0] d, input logic [7:0] l,
                             input logic [2:0] b, input logic on);
      for (int n = 0; n < 19; n++) exp_q.push_back(model_word(d, l, b, on, n));
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // ---------------- driver: one cycle on the main DUT ----------------
   // Inputs change at negedge; outputs are sampled 1 time unit later.
   task automatic run_cycle(input logic full, input logic upd);
      logic [17:0] e;
      @(negedge clk);
      fifo_full = full;
      update    = upd;
      #1;
      cyc++;
      if (stab_en && prev_stall) chk("stall_data_stable", 32'(data), 32'(prev_data));
      prev_stall = full && busy;
      prev_data  = data;
      if (full) chk("valid_while_full", 32'(data_valid), 32'(0));
      last_valid = data_valid;
      if (data_valid) begin
         // 0x3FFFF can never be a legal word (bits 15:8 are always zero).
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else                  e = 18'h3FFFF;
         chk("word", 32'(data), 32'(e));
         words_done++;
         word_cyc.push_back(cyc);
      end
   endtask

   task automatic run_frame(input int budget, input int full_pct);
      words_done = 0;
      run_cycle(1'b0, 1'b1);
      for (int it = 0; it < budget && (exp_q.size() > 0 || busy); it++)
         run_cycle(($urandom_range(0, 99) < full_pct), 1'b0);
      chk("frame_drained", 32'(exp_q.size()), 32'(0));
      chk("busy_after_frame", 32'(busy), 32'(0));
   endtask

   task automatic random_image();
      digits     = {$urandom(), $urandom()};
      leds       = 8'($urandom());
      bright     = 3'($urandom_range(0, 7));
      display_on = 1'($urandom_range(0, 1));
   endtask

   // ---------------- refresh DUT monitoring ----------------
   int rf_starts[$];
   int rf_widx = 0;
   int exp_starts[5] = '{40, 80, 120, 200, 240};

   // ---------------- directed sequence ----------------
   logic f;
   logic u;
   int   stall1;
   logic tog;
   bit   sent3;
   bit   sent10;

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("reset_valid", 32'(data_valid), 32'(0));
      chk("reset_data", 32'(data), 32'(0));
      chk("reset_busy", 32'(busy), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Test 1: reference image, no back-pressure, literal expected words
      digits = 64'h0706050403020100; leds = 8'hA5; bright = 3'd7; display_on = 1'b1;
      exp_q = '{18'h00040, 18'h100C0,
                18'h20000, 18'h20001, 18'h20001, 18'h20000, 18'h20002, 18'h20001,
                18'h20003, 18'h20000, 18'h20004, 18'h20000, 18'h20005, 18'h20001,
                18'h20006, 18'h20000, 18'h20007, 18'h30001, 18'h0008F};
      words_done = 0;
      run_cycle(1'b0, 1'b1);
      chk("idle_before_start", 32'(last_valid), 32'(0));
      for (int i = 0; i < 19; i++) begin
         run_cycle(1'b0, 1'b0);
         chk("consecutive_valid", 32'(last_valid), 32'(1));
      end
      run_cycle(1'b0, 1'b0);
      chk("t1_busy_after", 32'(busy), 32'(0));
      chk("t1_valid_after", 32'(data_valid), 32'(0));
      chk("t1_drained", 32'(exp_q.size()), 32'(0));

      // Test 2: same image, stalls of 5 cycles at W1 and alternating from W6
      push_frame(digits, leds, bright, display_on);
      words_done = 0; stall1 = 0; tog = 1'b1; stab_en = 1; prev_stall = 0;
      run_cycle(1'b0, 1'b1);
      for (int it = 0; it < 100 && (exp_q.size() > 0 || busy); it++) begin
         f = 1'b0;
         if (words_done == 1 && stall1 < 5) begin
            f = 1'b1;
            stall1++;
         end else if (words_done >= 6) begin
            f   = tog;
            tog = ~tog;
         end
         run_cycle(f, 1'b0);
      end
      stab_en = 0;
      chk("t2_drained", 32'(exp_q.size()), 32'(0));
      chk("t2_busy_after", 32'(busy), 32'(0));

      // Test 3: requests at W3 and W10, image changed to all ones at W3
      random_image();
      push_frame(digits, leds, bright, display_on);
      word_cyc.delete();
      words_done = 0; sent3 = 0; sent10 = 0;
      run_cycle(1'b0, 1'b1);
      for (int it = 0; it < 100 && (exp_q.size() > 0 || busy); it++) begin
         u = 1'b0;
         if (words_done == 3 && !sent3) begin
            sent3 = 1; u = 1'b1;
            digits = '1; leds = '1;
            push_frame(digits, leds, bright, display_on);
         end else if (words_done == 10 && !sent10) begin
            sent10 = 1; u = 1'b1;
         end
         run_cycle(1'b0, u);
      end
      repeat (25) run_cycle(1'b0, 1'b0);
      chk("t3_word_total", 32'(word_cyc.size()), 32'(38));
      if (word_cyc.size() >= 20)
         chk("t3_second_frame_gap", 32'(word_cyc[19] - word_cyc[18]), 32'(2));
      chk("t3_busy_after", 32'(busy), 32'(0));

      // Test 4: auto refresh every 40 cycles, 60-cycle full window
      @(negedge clk);
      rf_rst_n = 1'b1;
      for (int it = 1; it <= 250; it++) begin
         @(negedge clk);
         rf_full = (it >= 130 && it <= 189);
         #1;
         if (rf_full) chk("rf_valid_while_full", 32'(rf_valid), 32'(0));
         if (rf_valid) begin
            if (rf_widx == 0) rf_starts.push_back(it);
            chk("rf_word", 32'(rf_data),
                32'(model_word(rf_digits, rf_leds, rf_bright, rf_on, rf_widx)));
            rf_widx = (rf_widx + 1) % 19;
         end
      end
      chk("rf_frame_count", 32'(rf_starts.size()), 32'(5));
      for (int i = 0; i < 5; i++)
         if (i < rf_starts.size()) chk("rf_frame_start", 32'(rf_starts[i]), 32'(exp_starts[i]));

      // Test 5: reset while W9 is offered, with a pending request queued
      random_image();
      push_frame(digits, leds, bright, display_on);
      words_done = 0;
      run_cycle(1'b0, 1'b1);
      for (int it = 0; it < 40 && words_done < 9; it++)
         run_cycle(1'b0, (words_done == 5));
      @(negedge clk);
      #1;
      chk("t5_w9_offered", 32'(data_valid), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("t5_reset_valid", 32'(data_valid), 32'(0));
      chk("t5_reset_busy", 32'(busy), 32'(0));
      chk("t5_reset_data", 32'(data), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      random_image();
      push_frame(digits, leds, bright, display_on);
      run_frame(60, 0);

      // Test 6: brightness 0, display off -> control byte 0x80
      random_image();
      bright = 3'd0; display_on = 1'b0;
      push_frame(digits, leds, bright, display_on);
      run_frame(60, 0);

      // Test 7: random images under random back-pressure
      for (int k = 0; k < 3; k++) begin
         random_image();
         push_frame(digits, leds, bright, display_on);
         run_frame(200, 35);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
